// File: rtl/alarme_pkg.sv
// Shared state encoding and width helper for the seatbelt warning controller.
package alarme_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRACE  = 2'd1;
  localparam logic [1:0] ST_ALERT  = 2'd2;
  localparam logic [1:0] ST_REMIND = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    GRACE  = ST_GRACE,
    ALERT  = ST_ALERT,
    REMIND = ST_REMIND
  } state_t;

  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alarme_tick.sv
// Timing prescaler: one-cycle tick every TICK_DIV clocks, restartable
// with a synchronous clear.
module alarme_tick
  import alarme_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int PW = clog2w(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pcnt;

  assign tick = (pcnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (clr || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/alarme_ctrl.sv
// Seatbelt warning sequencer: IDLE -> GRACE -> ALERT (blink+buzzer) -> REMIND.
// Optional belt debounce with macro ALARME_DEBOUNCE_EN.
module alarme_ctrl
  import alarme_pkg::*;
#(
  parameter int TICK_DIV         = 1000,
  parameter int GRACE_TICKS      = 5,
  parameter int ALERT_TICKS      = 30,
  parameter int BLINK_HALF_TICKS = 1,
  parameter int DEB_CYCLES       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       moto,
  input  logic       cinto,
  input  logic       igni,
  output logic       luz,
  output logic       bip,
  output logic [1:0] estado
);

  if (TICK_DIV < 1 || GRACE_TICKS < 1 || ALERT_TICKS < 1 ||
      BLINK_HALF_TICKS < 1 || DEB_CYCLES < 1) begin : g_bad_param
    $error("alarme_ctrl: all parameters must be >= 1");
  end

  localparam int MAX_GA = (GRACE_TICKS > ALERT_TICKS) ?
                          GRACE_TICKS : ALERT_TICKS;
  localparam int MAXT = (MAX_GA > BLINK_HALF_TICKS) ?
                        MAX_GA : BLINK_HALF_TICKS;
  localparam int TW = $clog2(MAXT) + 1;

  localparam logic [TW-1:0] G_LAST = TW'(GRACE_TICKS - 1);
  localparam logic [TW-1:0] A_LAST = TW'(ALERT_TICKS - 1);
  localparam logic [TW-1:0] B_LAST = TW'(BLINK_HALF_TICKS - 1);

  logic [2:0] sync1;
  logic [2:0] sync2;
  logic       moto_s;
  logic       cinto_s;
  logic       igni_s;
  logic       cinto_f;
  logic       cond;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {moto, cinto, igni};
      sync2 <= sync1;
    end
  end

  assign moto_s  = sync2[2];
  assign cinto_s = sync2[1];
  assign igni_s  = sync2[0];

`ifdef ALARME_DEBOUNCE_EN
  localparam int DW = clog2w(DEB_CYCLES) + 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] dcnt;

  // Belt state follows only after DEB_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt    <= '0;
      cinto_f <= 1'b0;
    end else if (cinto_s == cinto_f) begin
      dcnt <= '0;
    end else if (dcnt == D_LAST) begin
      dcnt    <= '0;
      cinto_f <= cinto_s;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end
`else
  assign cinto_f = cinto_s;
`endif

  assign cond = moto_s & ~cinto_f & igni_s;

  state_t        state;
  state_t        nxt;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] bcnt;
  logic          phase;
  logic          phase_nxt;
  logic          go;
  logic          flip;
  logic          tick;

  alarme_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (go),
    .tick (tick)
  );

  // Loss of cond always wins over a same-cycle expiry tick.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (cond) nxt = GRACE;
      GRACE:   if (!cond) nxt = IDLE;
               else if (tick && tcnt == G_LAST) nxt = ALERT;
      ALERT:   if (!cond) nxt = IDLE;
               else if (tick && tcnt == A_LAST) nxt = REMIND;
      REMIND:  if (!cond) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign go        = (nxt != state);
  assign flip      = (state == ALERT) && tick && (bcnt == B_LAST);
  assign phase_nxt = go ? 1'b1 : (phase ^ flip);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tcnt  <= '0;
      bcnt  <= '0;
      phase <= 1'b0;
      luz   <= 1'b0;
      bip   <= 1'b0;
    end else begin
      state <= nxt;
      phase <= phase_nxt;
      if (go) begin
        tcnt <= '0;
        bcnt <= '0;
      end else if (tick) begin
        if (tcnt != '1) tcnt <= tcnt + 1'b1;
        if (state == ALERT) bcnt <= flip ? '0 : bcnt + 1'b1;
      end
      luz <= (nxt == ALERT) ? phase_nxt : (nxt != IDLE);
      bip <= (nxt == ALERT) & phase_nxt;
    end
  end

  assign estado = state;

endmodule

// File: tb/tb_alarme_ctrl.sv
// Directed self-checking bench for alarme_ctrl.
// Small timing parameters; belt debounce steps follow ALARME_DEBOUNCE_EN.
module tb_alarme_ctrl;

  localparam int TD = 4;
  localparam int GT = 3;
  localparam int AT = 8;

`ifdef ALARME_DEBOUNCE_EN
  localparam int DL = 4;
`else
  localparam int DL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       moto = 1'b0;
  logic       cinto = 1'b0;
  logic       igni = 1'b0;
  logic       luz;
  logic       bip;
  logic [1:0] estado;

  int checks = 0;
  int failures = 0;

  alarme_ctrl #(
    .TICK_DIV        (TD),
    .GRACE_TICKS     (GT),
    .ALERT_TICKS     (AT),
    .BLINK_HALF_TICKS(1),
    .DEB_CYCLES      (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .moto  (moto),
    .cinto (cinto),
    .igni  (igni),
    .luz   (luz),
    .bip   (bip),
    .estado(estado)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] E_IDLE   = {2'd0, 1'b0, 1'b0};
  localparam logic [3:0] E_GRACE  = {2'd1, 1'b1, 1'b0};
  localparam logic [3:0] E_AON    = {2'd2, 1'b1, 1'b1};
  localparam logic [3:0] E_AOFF   = {2'd2, 1'b0, 1'b0};
  localparam logic [3:0] E_REMIND = {2'd3, 1'b1, 1'b0};

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input logic [2:0] v);
    {moto, cinto, igni} = v;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {estado, luz, bip};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] alert_at(input int k);
    return ((k / TD) % 2 == 0) ? E_AON : E_AOFF;
  endfunction

  initial begin
    cyc(2);
    chk("reset_state", E_IDLE);
    rst_n = 1'b1;
    cyc(2);

    // truth sweep: only 101 leaves IDLE
    for (int v = 0; v < 8; v++) begin
      if (v != 5) begin
        set_in(3'(v));
        cyc(20);
        chk($sformatf("sweep_%0d", v), E_IDLE);
      end
    end
    set_in(3'b000);
    cyc(3);

    // full sequence
    set_in(3'b101);
    cyc(2);
    chk("seq_latency_idle", E_IDLE);
    cyc(1);
    chk("seq_grace_first", E_GRACE);
    cyc(GT * TD - 1);
    chk("seq_grace_last", E_GRACE);
    cyc(1);
    chk("seq_alert_0", alert_at(0));
    for (int k = 1; k < AT * TD; k++) begin
      cyc(1);
      chk($sformatf("seq_alert_%0d", k), alert_at(k));
    end
    cyc(1);
    chk("seq_remind", E_REMIND);
    cyc(40);
    chk("seq_remind_hold", E_REMIND);

    // leave, then abort mid-ALERT with belt
    set_in(3'b000);
    cyc(3);
    chk("drop_to_idle", E_IDLE);
    set_in(3'b101);
    cyc(3 + GT * TD + 20);
    chk("abort_alert_20", alert_at(20));
    set_in(3'b111);
    cyc(2 + DL);
    chk("abort_pre", alert_at(22 + DL));
    cyc(1);
    chk("abort_idle", E_IDLE);
    set_in(3'b101);
    cyc(2 + DL);
    chk("reentry_pre", E_IDLE);
    cyc(1);
    chk("reentry_grace", E_GRACE);
    cyc(GT * TD - 1);
    chk("reentry_grace_last", E_GRACE);
    cyc(1);
    chk("reentry_alert", E_AON);

    // collision: cond falls on the GRACE expiry edge
    set_in(3'b000);
    cyc(3);
    chk("coll_idle0", E_IDLE);
    set_in(3'b101);
    cyc(3);
    chk("coll_grace", E_GRACE);
    cyc(GT * TD - 3);
    set_in(3'b100);
    cyc(2);
    chk("coll_grace_last", E_GRACE);
    cyc(1);
    chk("coll_idle", E_IDLE);
    cyc(5);
    chk("coll_stay_idle", E_IDLE);

    // asynchronous reset mid-ALERT
    set_in(3'b101);
    cyc(3 + GT * TD + 5);
    chk("rst_pre_alert", alert_at(5));
    #2 rst_n = 1'b0;
    #1 chk("rst_async", E_IDLE);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    chk("rst_release_idle", E_IDLE);
    cyc(1);
    chk("rst_release_grace", E_GRACE);

`ifdef ALARME_DEBOUNCE_EN
    cyc(GT * TD + AT * TD);
    chk("deb_remind", E_REMIND);
    set_in(3'b111);
    cyc(3);
    set_in(3'b101);
    cyc(10);
    chk("deb_glitch", E_REMIND);
    set_in(3'b111);
    cyc(2 + DL);
    chk("deb_pre", E_REMIND);
    cyc(1);
    chk("deb_idle", E_IDLE);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
